ifu_fetch: RTL and testbench



---
 rtl/ifu_fetch.sv | 162 ++++++++++++++++
 tb/tb_ifu_fetch.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifu_fetch.sv
// Instruction fetch unit: issues one word read at a time on the vrb bus and holds
// one fetched instruction for the execute stage, redirecting on taken jumps.
module ifu_fetch #(
    parameter int              AW       = 32,
    parameter int              DW       = 32,
    parameter logic [AW-1:0]   RESET_PC = {AW{1'b0}}
) (
    input  logic              clk,
    input  logic              rst_n,

    output logic              o_vrb_cmd_valid,
    input  logic              i_vrb_cmd_ready,
    output logic [AW-1:0]     o_vrb_cmd_addr,
    output logic              o_vrb_cmd_read,
    output logic [DW-1:0]     o_vrb_cmd_wdata,
    output logic [DW/8-1:0]   o_vrb_cmd_wmask,
    input  logic              i_vrb_rsp_valid,
    output logic              o_vrb_rsp_ready,
    input  logic              i_vrb_rsp_err,
    input  logic [DW-1:0]     i_vrb_rsp_rdata,

    output logic              o_instr_valid,
    input  logic              i_instr_ready,
    output logic [DW-1:0]     o_instr,
    output logic [AW-1:0]     o_pc_cur,
    output logic              o_instr_fault,
    input  logic              i_jump_valid,
    input  logic [AW-1:0]     i_jump_pc
);

    localparam logic [DW-1:0] NOP_INSTR  = DW'(32'h0000_0013);
    localparam logic [AW-1:0] ALIGN_MASK = ~AW'(3);
    localparam logic [AW-1:0] PC_STEP    = AW'(4);

    logic              started_q,     started_d;
    logic              outstanding_q, outstanding_d;
    logic              drop_q,        drop_d;
    logic [AW-1:0]     fetch_pc_q,    fetch_pc_d;
    logic [AW-1:0]     req_pc_q,      req_pc_d;
    logic              jump_pend_q,   jump_pend_d;
    logic [AW-1:0]     jump_pc_q,     jump_pc_d;
    logic              instr_valid_q, instr_valid_d;
    logic [DW-1:0]     instr_q,       instr_d;
    logic [AW-1:0]     pc_cur_q,      pc_cur_d;
    logic              fault_q,       fault_d;

    logic              cmd_valid;
    logic              cmd_hs;
    logic              accept;
    logic              redirect;
    logic              rsp_ready;
    logic              rsp_hs;
    logic              load;
    logic [AW-1:0]     jump_tgt;

    always_comb begin
        cmd_valid = started_q & ~outstanding_q;
        cmd_hs    = cmd_valid & i_vrb_cmd_ready;
        accept    = instr_valid_q & i_instr_ready;
        redirect  = accept & i_jump_valid;
        rsp_ready = drop_q | ~instr_valid_q | accept;
        rsp_hs    = i_vrb_rsp_valid & rsp_ready & outstanding_q;
        load      = rsp_hs & ~drop_q & ~redirect;
        jump_tgt  = i_jump_pc & ALIGN_MASK;
    end

    always_comb begin
        started_d     = 1'b1;
        outstanding_d = outstanding_q;
        drop_d        = drop_q;
        fetch_pc_d    = fetch_pc_q;
        req_pc_d      = req_pc_q;
        jump_pend_d   = jump_pend_q;
        jump_pc_d     = jump_pc_q;
        instr_valid_d = instr_valid_q;
        instr_d       = instr_q;
        pc_cur_d      = pc_cur_q;
        fault_d       = fault_q;

        if (cmd_hs) begin
            outstanding_d = 1'b1;
            req_pc_d      = fetch_pc_q;
        end else if (rsp_hs) begin
            outstanding_d = 1'b0;
        end

        if (rsp_hs) begin
            drop_d = 1'b0;
        end

        // A request held by a stalled bus keeps its address; the jump target is
        // parked and takes over once that stale request is accepted.
        if (cmd_hs && jump_pend_q) begin
            fetch_pc_d  = jump_pc_q;
            jump_pend_d = 1'b0;
            drop_d      = 1'b1;
        end else if (cmd_hs) begin
            fetch_pc_d = fetch_pc_q + PC_STEP;
        end

        if (redirect) begin
            if (cmd_valid && !i_vrb_cmd_ready) begin
                jump_pend_d = 1'b1;
                jump_pc_d   = jump_tgt;
            end else begin
                fetch_pc_d = jump_tgt;
            end
            if ((outstanding_q && !rsp_hs) || cmd_hs) begin
                drop_d = 1'b1;
            end
        end

        if (load) begin
            instr_valid_d = 1'b1;
            instr_d       = i_vrb_rsp_err ? NOP_INSTR : i_vrb_rsp_rdata;
            pc_cur_d      = req_pc_q;
            fault_d       = i_vrb_rsp_err;
        end else if (accept) begin
            instr_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q     <= 1'b0;
            outstanding_q <= 1'b0;
            drop_q        <= 1'b0;
            fetch_pc_q    <= RESET_PC;
            req_pc_q      <= RESET_PC;
            jump_pend_q   <= 1'b0;
            jump_pc_q     <= {AW{1'b0}};
            instr_valid_q <= 1'b0;
            instr_q       <= {DW{1'b0}};
            pc_cur_q      <= {AW{1'b0}};
            fault_q       <= 1'b0;
        end else begin
            started_q     <= started_d;
            outstanding_q <= outstanding_d;
            drop_q        <= drop_d;
            fetch_pc_q    <= fetch_pc_d;
            req_pc_q      <= req_pc_d;
            jump_pend_q   <= jump_pend_d;
            jump_pc_q     <= jump_pc_d;
            instr_valid_q <= instr_valid_d;
            instr_q       <= instr_d;
            pc_cur_q      <= pc_cur_d;
            fault_q       <= fault_d;
        end
    end

    assign o_vrb_cmd_valid = cmd_valid;
    assign o_vrb_cmd_addr  = fetch_pc_q;
    assign o_vrb_cmd_read  = 1'b1;
    assign o_vrb_cmd_wdata = {DW{1'b0}};
    assign o_vrb_cmd_wmask = {(DW/8){1'b0}};
    assign o_vrb_rsp_ready = rsp_ready;
    assign o_instr_valid   = instr_valid_q;
    assign o_instr         = instr_q;
    assign o_pc_cur        = pc_cur_q;
    assign o_instr_fault   = fault_q;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: a small vrb memory and execute-stage model,
// with fetch and accept traces compared against hand-derived sequences.
module tb_ifu_fetch;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        o_vrb_cmd_valid;
    logic        i_vrb_cmd_ready = 1'b0;
    logic [31:0] o_vrb_cmd_addr;
    logic        o_vrb_cmd_read;
    logic [31:0] o_vrb_cmd_wdata;
    logic [3:0]  o_vrb_cmd_wmask;
    logic        i_vrb_rsp_valid = 1'b0;
    logic        o_vrb_rsp_ready;
    logic        i_vrb_rsp_err = 1'b0;
    logic [31:0] i_vrb_rsp_rdata = '0;
    logic        o_instr_valid;
    logic        i_instr_ready = 1'b0;
    logic [31:0] o_instr;
    logic [31:0] o_pc_cur;
    logic        o_instr_fault;
    logic        i_jump_valid = 1'b0;
    logic [31:0] i_jump_pc = '0;

    ifu_fetch dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .o_vrb_cmd_valid (o_vrb_cmd_valid),
        .i_vrb_cmd_ready (i_vrb_cmd_ready),
        .o_vrb_cmd_addr  (o_vrb_cmd_addr),
        .o_vrb_cmd_read  (o_vrb_cmd_read),
        .o_vrb_cmd_wdata (o_vrb_cmd_wdata),
        .o_vrb_cmd_wmask (o_vrb_cmd_wmask),
        .i_vrb_rsp_valid (i_vrb_rsp_valid),
        .o_vrb_rsp_ready (o_vrb_rsp_ready),
        .i_vrb_rsp_err   (i_vrb_rsp_err),
        .i_vrb_rsp_rdata (i_vrb_rsp_rdata),
        .o_instr_valid   (o_instr_valid),
        .i_instr_ready   (i_instr_ready),
        .o_instr         (o_instr),
        .o_pc_cur        (o_pc_cur),
        .o_instr_fault   (o_instr_fault),
        .i_jump_valid    (i_jump_valid),
        .i_jump_pc       (i_jump_pc)
    );

    always #5 clk = ~clk;

    // scenario knobs, written only by the main sequence
    int          rsp_lat   = 1;
    logic        exec_ready = 1'b1;
    logic        err_en    = 1'b0;
    logic [31:0] err_addr  = '0;
    logic        jump_arm  = 1'b0;
    logic [31:0] jump_at   = '0;
    logic [31:0] jump_tgt  = '0;
    int          jump_wait = 0;
    logic        blk_en    = 1'b0;
    logic [31:0] blk_addr  = '0;
    int          blk_len   = 0;

    // model state and traces, written only by the bus/execute model
    logic        bus_pend;
    logic [31:0] bus_addr;
    int          bus_cnt;
    logic        jump_done;
    int          wait_used;
    int          blk_used;
    int          cyc;
    logic        f_cmd, f_rsp, f_acc, f_flt, hold, armed;
    logic [31:0] f_addr, f_pc, f_ins;
    logic [31:0] cmd_log[$];
    logic [31:0] acc_pc[$];
    logic [31:0] acc_ins[$];
    logic [31:0] acc_flt[$];
    logic [31:0] acc_cyc[$];

    int n_chk = 0;
    int n_err = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (32'hA000_0000 | a);
    endfunction

    function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
        return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change only at negedge; handshakes seen there complete at the next posedge.
    always @(negedge clk) begin
        if (!rst_n) begin
            bus_pend = 1'b0; bus_addr = '0; bus_cnt = 0;
            i_vrb_rsp_valid = 1'b0; i_vrb_rsp_err = 1'b0; i_vrb_rsp_rdata = '0;
            i_vrb_cmd_ready = 1'b0; i_instr_ready = 1'b0; i_jump_valid = 1'b0;
            f_cmd = 1'b0; f_rsp = 1'b0; f_acc = 1'b0;
            jump_done = 1'b0; wait_used = 0; blk_used = 0; cyc = 0;
            cmd_log.delete(); acc_pc.delete(); acc_ins.delete(); acc_flt.delete(); acc_cyc.delete();
        end else begin
            cyc++;
            if (f_acc) begin
                acc_pc.push_back(f_pc); acc_ins.push_back(f_ins);
                acc_flt.push_back({31'b0, f_flt}); acc_cyc.push_back(cyc);
            end
            if (f_rsp) begin
                bus_pend = 1'b0;
                i_vrb_rsp_valid = 1'b0;
            end
            if (f_cmd) begin
                bus_pend = 1'b1; bus_addr = f_addr; bus_cnt = rsp_lat;
                cmd_log.push_back(f_addr);
            end
            if (bus_pend && !i_vrb_rsp_valid) begin
                if (bus_cnt <= 1) begin
                    i_vrb_rsp_valid = 1'b1;
                    i_vrb_rsp_rdata = mem_word(bus_addr);
                    i_vrb_rsp_err   = err_en && (bus_addr == err_addr);
                end else begin
                    bus_cnt--;
                end
            end
            i_vrb_cmd_ready = !(blk_en && blk_used < blk_len && o_vrb_cmd_valid && o_vrb_cmd_addr == blk_addr);
            if (!i_vrb_cmd_ready) blk_used++;
            armed = jump_arm && !jump_done && o_instr_valid && (o_pc_cur == jump_at);
            hold  = armed && (wait_used < jump_wait);
            if (hold) wait_used++;
            i_instr_ready = exec_ready && !hold;
            i_jump_valid  = armed && !hold;
            i_jump_pc     = jump_tgt;
            #1;
            f_cmd  = o_vrb_cmd_valid && i_vrb_cmd_ready;
            f_addr = o_vrb_cmd_addr;
            f_rsp  = i_vrb_rsp_valid && o_vrb_rsp_ready;
            f_acc  = o_instr_valid && i_instr_ready;
            f_pc   = o_pc_cur; f_ins = o_instr; f_flt = o_instr_fault;
            if (f_acc && i_jump_valid) jump_done = 1'b1;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step(2);
        rsp_lat = 1; exec_ready = 1'b1; err_en = 1'b0; jump_arm = 1'b0;
        jump_wait = 0; blk_en = 1'b0;
    endtask

    initial begin
        // reset release and sequential fetch
        step(3);
        check("rst_cmd_valid", {31'b0, o_vrb_cmd_valid}, 32'd0);
        check("rst_instr_valid", {31'b0, o_instr_valid}, 32'd0);
        check("rst_instr", o_instr, 32'h0);
        check("rst_pc", o_pc_cur, 32'h0);
        check("rst_fault", {31'b0, o_instr_fault}, 32'd0);
        check("const_read", {31'b0, o_vrb_cmd_read}, 32'd1);
        rst_n = 1'b1;
        #1;
        check("no_early_req", {31'b0, o_vrb_cmd_valid}, 32'd0);
        step(1);
        check("first_req_valid", {31'b0, o_vrb_cmd_valid}, 32'd1);
        check("first_req_addr", o_vrb_cmd_addr, 32'h0);
        step(20);
        for (int i = 0; i < 4; i++) check("seq_cmd", qat(cmd_log, i), 32'(4 * i));
        for (int i = 0; i < 3; i++) check("seq_pc", qat(acc_pc, i), 32'(4 * i));
        check("seq_ins0", qat(acc_ins, 0), 32'h0050_0093);
        check("seq_ins2", qat(acc_ins, 2), 32'hA000_0008);
        check("seq_spacing", qat(acc_cyc, 1) - qat(acc_cyc, 0), 32'd2);

        // back-pressure: buffer full, second response stalls
        reset_dut();
        exec_ready = 1'b0;
        rst_n = 1'b1;
        step(10);
        check("bp_valid", {31'b0, o_instr_valid}, 32'd1);
        check("bp_instr", o_instr, 32'h0050_0093);
        check("bp_pc", o_pc_cur, 32'h0);
        check("bp_ncmd", 32'(cmd_log.size()), 32'd2);
        check("bp_cmd1", qat(cmd_log, 1), 32'h4);
        check("bp_rsp_valid", {31'b0, i_vrb_rsp_valid}, 32'd1);
        check("bp_rsp_ready", {31'b0, o_vrb_rsp_ready}, 32'd0);
        check("bp_cmd_idle", {31'b0, o_vrb_cmd_valid}, 32'd0);
        exec_ready = 1'b1;
        step(6);
        check("bp_acc0", qat(acc_pc, 0), 32'h0);
        check("bp_acc1", qat(acc_pc, 1), 32'h4);
        check("bp_no_bubble", qat(acc_cyc, 1) - qat(acc_cyc, 0), 32'd1);

        // redirect while 0xC is outstanding
        reset_dut();
        rsp_lat = 3; jump_arm = 1'b1; jump_at = 32'h8; jump_tgt = 32'h103; jump_wait = 2;
        rst_n = 1'b1;
        step(40);
        check("jmp_cmd3", qat(cmd_log, 3), 32'hC);
        check("jmp_cmd4", qat(cmd_log, 4), 32'h100);
        check("jmp_cmd5", qat(cmd_log, 5), 32'h104);
        check("jmp_acc2", qat(acc_pc, 2), 32'h8);
        check("jmp_acc3", qat(acc_pc, 3), 32'h100);
        check("jmp_ins3", qat(acc_ins, 3), 32'hA000_0100);
        check("jmp_acc4", qat(acc_pc, 4), 32'h104);

        // errored response
        reset_dut();
        err_en = 1'b1; err_addr = 32'h4;
        rst_n = 1'b1;
        step(20);
        check("err_flt0", qat(acc_flt, 0), 32'd0);
        check("err_pc", qat(acc_pc, 1), 32'h4);
        check("err_ins", qat(acc_ins, 1), 32'h0000_0013);
        check("err_flt", qat(acc_flt, 1), 32'd1);
        check("err_next_pc", qat(acc_pc, 2), 32'h8);
        check("err_next_ins", qat(acc_ins, 2), 32'hA000_0008);
        check("err_next_flt", qat(acc_flt, 2), 32'd0);

        // redirect while the bus refuses the pending 0xC request
        reset_dut();
        jump_arm = 1'b1; jump_at = 32'h8; jump_tgt = 32'h200;
        blk_en = 1'b1; blk_addr = 32'hC; blk_len = 5;
        rst_n = 1'b1;
        for (int i = 0; i < 50 && blk_used < 3; i++) step(1);
        check("stall_seen", {31'b0, blk_used >= 3}, 32'd1);
        check("stall_valid", {31'b0, o_vrb_cmd_valid}, 32'd1);
        check("stall_addr", o_vrb_cmd_addr, 32'hC);
        check("stall_buf_inv", {31'b0, o_instr_valid}, 32'd0);
        check("stall_jumped", {31'b0, jump_done}, 32'd1);
        step(30);
        check("stall_cmd3", qat(cmd_log, 3), 32'hC);
        check("stall_cmd4", qat(cmd_log, 4), 32'h200);
        check("stall_acc3", qat(acc_pc, 3), 32'h200);
        check("stall_ins3", qat(acc_ins, 3), 32'hA000_0200);

        // asynchronous reset mid-wait
        reset_dut();
        exec_ready = 1'b0;
        rst_n = 1'b1;
        step(10);
        check("ar_pre_valid", {31'b0, o_instr_valid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("ar_cmd_valid", {31'b0, o_vrb_cmd_valid}, 32'd0);
        check("ar_instr_valid", {31'b0, o_instr_valid}, 32'd0);
        check("ar_instr", o_instr, 32'h0);
        check("ar_pc", o_pc_cur, 32'h0);
        check("ar_fault", {31'b0, o_instr_fault}, 32'd0);
        step(2);
        exec_ready = 1'b1;
        rst_n = 1'b1;
        step(15);
        check("ar_restart_cmd", qat(cmd_log, 0), 32'h0);
        check("ar_restart_pc", qat(acc_pc, 0), 32'h0);
        check("ar_restart_pc1", qat(acc_pc, 1), 32'h4);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
